// File: rtl/multi_timer.sv
// multi_timer: NUM_CH programmable down-counting timer channels with a shared write-1-to-clear STATUS register
module multi_timer #(
  parameter int          NUM_CH    = 2,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              we,
  output logic [31:0]       rdata,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'(16 * NUM_CH);
  logic [NUM_CH-1:0] en, im, expire, pending;
  logic [1:0]        mode   [NUM_CH];
  logic [CNT_W-1:0]  preset [NUM_CH];
  logic [CNT_W-1:0]  count  [NUM_CH];
  genvar c;
  for (c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [31:0] A = BASE_ADDR + 32'(16 * c);
    logic             ctrl_wr, preset_wr, run, en_r, im_r;
    logic [1:0]       mode_r;
    logic [CNT_W-1:0] preset_r, count_r;
    assign ctrl_wr   = we && addr == A;
    assign preset_wr = we && addr == A + 32'd4;
    // a register write to this channel suppresses its FSM step, including expiry
    assign expire[c] = !ctrl_wr && !preset_wr && run && en_r && count_r <= CNT_W'(1);
    assign en[c]     = en_r;
    assign im[c]     = im_r;
    assign mode[c]   = mode_r;
    assign preset[c] = preset_r;
    assign count[c]  = count_r;
    always_ff @(posedge clk) begin
      if (reset) begin
        en_r     <= 1'b0;
        im_r     <= 1'b0;
        mode_r   <= 2'b00;
        run      <= 1'b0;
        preset_r <= '0;
        count_r  <= '0;
      end else if (ctrl_wr) begin
        en_r   <= wdata[0];
        mode_r <= wdata[2:1];
        im_r   <= wdata[3];
        run    <= 1'b0;
      end else if (preset_wr) begin
        preset_r <= wdata[CNT_W-1:0];
      end else if (!run) begin
        if (en_r) begin
          count_r <= preset_r;
          run     <= 1'b1;
        end
      end else if (!en_r) begin
        run <= 1'b0;
      end else if (count_r > CNT_W'(1)) begin
        count_r <= count_r - CNT_W'(1);
      end else if (mode_r == 2'b01) begin
        count_r <= preset_r;
      end else begin
        count_r <= '0;
        en_r    <= 1'b0;
        run     <= 1'b0;
      end
    end
  end
  // expiry is ORed in after the clear so a same-edge set wins
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else pending <= (pending & ~((we && addr == STATUS_ADDR) ? wdata[NUM_CH-1:0] : '0)) | expire;
  end
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr == BASE_ADDR + 32'(16 * i)) rdata = {28'd0, im[i], mode[i], en[i]};
      if (addr == BASE_ADDR + 32'(16 * i) + 32'd4) rdata = 32'(preset[i]);
      if (addr == BASE_ADDR + 32'(16 * i) + 32'd8) rdata = 32'(count[i]);
    end
    if (addr == STATUS_ADDR) rdata = 32'(pending);
  end
  assign irq_vec = pending & im;
  assign irq     = |irq_vec;
endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Parametrised multi-channel programmable timer on the CPU memory-mapped device bus; the next generation of the single-channel bridge timer.
- NUM_CH independent channels. Each channel has CTRL, PRESET and read-only COUNT registers, and runs one-shot or auto-reload.
- A shared sticky STATUS register holds pending flags (write-1-to-clear).
- Per-channel masked interrupt vector plus an ORed request feed the CP0 interrupt lines.

Parameters:
- NUM_CH, 2, number of timer channels (1..8).
- CNT_W, 32, counter/preset width in bits (8..32).
- BASE_ADDR, 32'h0000_7F00, byte address of channel 0 CTRL.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- addr  input  32  byte address from bridge
- wdata  input  32  write data
- we  input  1  write strobe, one cycle per write
- rdata  output  32  combinational read data for addr
- irq_vec  output  NUM_CH  per-channel request = pending & im
- irq  output  1  OR of irq_vec

Behaviour:
- Register map. Channel c occupies BASE_ADDR + 16*c:
  - +0 CTRL: bit0 enable, bits2:1 mode, bit3 im; bits 31:4 read 0.
  - +4 PRESET: CNT_W bits.
  - +8 COUNT: read-only; writes ignored.
  - +12: reserved, reads 0.
- STATUS lives at BASE_ADDR + 16*NUM_CH. Bit c is pending[c]; upper bits read 0. Writing 1 to a bit clears it; writing 0 leaves it.
- Address decode: full 32-bit compare. Unmapped addresses read 0 and ignore writes.
- rdata is zero-extended from CNT_W. PRESET writes take wdata[CNT_W-1:0].
- Modes:
  - 00 one-shot.
  - 01 auto-reload.
  - 10 and 11 behave as 00 but read back as written.
- Reset: all CTRL, PRESET, COUNT and pending bits 0; every channel IDLE; irq_vec = 0, irq = 0.
- Per-channel FSM, states IDLE and COUNTING:
  - IDLE & enable: COUNT <= PRESET, go to COUNTING.
  - COUNTING & COUNT > 1: COUNT <= COUNT-1.
  - COUNTING & COUNT <= 1 (expiry):
    - pending[c] <= 1.
    - Mode 00: COUNT <= 0, enable <= 0, go to IDLE.
    - Mode 01: COUNT <= PRESET, stay in COUNTING.
  - COUNTING & !enable: go to IDLE, COUNT holds its value.
- Latency: CTRL write with enable=1 at edge E on an IDLE channel with PRESET = P ≥ 1:
  - COUNT = P at edge E+1.
  - Expiry (pending set) at edge E+P+1.
  - Auto-reload period is P cycles.
  - PRESET = 0 behaves as PRESET = 1.
- Write priority:
  - A write to a channel's CTRL or PRESET replaces that channel's FSM action for that edge.
  - Other channels keep counting; a write never stalls other channels.
- CTRL write semantics:
  - Loads im, mode and enable.
  - If the channel is COUNTING, the FSM goes to IDLE. If the new enable=1, the channel reloads from PRESET on the next edge, so the count restarts.
- PRESET write while COUNTING: COUNT is unaffected; the new value is used at the next load or reload.
- STATUS W1C in the same edge as an expiry on that bit: set wins, bit stays 1.
- Pending is sticky regardless of im. Setting im later asserts irq_vec[c] immediately (combinational).
- irq_vec and irq are combinational from registered pending and im, with no extra delay.
- Reset asserted mid-count: returns to the reset state on that edge and overrides any simultaneous write.

Test Plan:
1. Reset, then read all registers → CTRL/PRESET/COUNT/STATUS = 0, irq = 0; read 0x7F0C and an unmapped address → 0.
2. Ch0 PRESET = 5, CTRL = 0x9 (im=1, one-shot, en) at edge E:
   - COUNT = 5, 4, 3, 2, 1 at edges E+1..E+5.
   - At E+6: pending[0] = 1, irq = 1, CTRL reads 0x8, COUNT = 0.
   - Write STATUS = 0x1 → irq = 0.
3. Ch1 PRESET = 3, CTRL = 0xB (auto-reload):
   - pending[1] sets at E+4.
   - Clear it; it sets again at E+7.
   - Ch0 idle throughout with COUNT unchanged.
4. Ch0 counting from PRESET = 10; at COUNT = 4 write ch0 CTRL = 0x9:
   - Next edge COUNT unchanged, state IDLE; the edge after, COUNT = 10.
   - Ch1 decrements on every edge during this sequence.
5. Ch0 expiry edge coincides with STATUS write 0x1 → pending[0] remains 1. Ch0 CTRL = 0x1 (im=0) expiry → STATUS bit0 = 1, irq = 0; then CTRL = 0x8 → irq = 1.
6. CNT_W = 8 build: PRESET write 0x1FF → reads 0xFF, and expiry occurs 255 cycles after load. Reset mid-count → all registers 0 on the next read.
